// File: rtl/pcra_fetch_address.sv
// Address side of the fetch stage: PCRA0/PCRA1 program-counter/return-address pair,
// flip flag selecting the live PC, and single-bus arbitration between fetch and data access.
module pcra_fetch_address #(
    parameter int ADDR_W = 16
) (
    input  logic              ClockIn,
    input  logic              Reset_n,
    input  logic              Pipe0Out_0_IncPCRA0,
    input  logic              Pipe0Out_1_IncPCRA1,
    input  logic              LoadPCRA0,
    input  logic              LoadPCRA1,
    input  logic [ADDR_W-1:0] LoadData,
    input  logic              FlipToggle,
    input  logic              DataReq,
    input  logic [ADDR_W-1:0] DataAddr,
    output logic              DataAck,
    output logic              BusRequest,
    output logic              FetchSurpress,
    output logic              Flags_5_PCRA_Flip,
    output logic [ADDR_W-1:0] MEMADDR,
    output logic [ADDR_W-1:0] PCRA0,
    output logic [ADDR_W-1:0] PCRA1
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        DATA  = 2'd1,
        FLUSH = 2'd2
    } busState_t;

    busState_t         state;
    busState_t         stateNext;
    logic [ADDR_W-1:0] pcra0Q;
    logic [ADDR_W-1:0] pcra1Q;
    logic [ADDR_W-1:0] dataAddrQ;
    logic [ADDR_W-1:0] pcra0Next;
    logic [ADDR_W-1:0] pcra1Next;
    logic [ADDR_W-1:0] dataAddrNext;
    logic              flipQ;
    logic              flipNext;
    logic              liveLoad;
    logic              busBusy;
    logic              inc0Ok;
    logic              inc1Ok;

    // Modulo-2^ADDR_W increment: all-ones wraps to zero.
    function automatic logic [ADDR_W-1:0] incAddr(input logic [ADDR_W-1:0] a);
        return a + {{(ADDR_W-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        stateNext    = state;
        dataAddrNext = dataAddrQ;
        flipNext     = flipQ ^ FlipToggle;

        // Live-PC decisions use the flag as it stands before this edge's toggle.
        liveLoad = flipQ ? LoadPCRA1 : LoadPCRA0;
        busBusy  = (state != FETCH);
        inc0Ok   = Pipe0Out_0_IncPCRA0 && !(busBusy && !flipQ);
        inc1Ok   = Pipe0Out_1_IncPCRA1 && !(busBusy && flipQ);

        if (LoadPCRA0)
            pcra0Next = LoadData;
        else if (inc0Ok)
            pcra0Next = incAddr(pcra0Q);
        else
            pcra0Next = pcra0Q;

        if (LoadPCRA1)
            pcra1Next = LoadData;
        else if (inc1Ok)
            pcra1Next = incAddr(pcra1Q);
        else
            pcra1Next = pcra1Q;

        unique case (state)
            FETCH: begin
                if (liveLoad) begin
                    stateNext = FLUSH;
                end else if (DataReq) begin
                    stateNext    = DATA;
                    dataAddrNext = DataAddr;
                end
            end
            DATA:  stateNext = FETCH;
            FLUSH: stateNext = liveLoad ? FLUSH : FETCH;
            default: stateNext = FETCH;
        endcase
    end

    always_ff @(posedge ClockIn or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= FETCH;
            pcra0Q    <= '0;
            pcra1Q    <= '0;
            dataAddrQ <= '0;
            flipQ     <= 1'b0;
        end else begin
            state     <= stateNext;
            pcra0Q    <= pcra0Next;
            pcra1Q    <= pcra1Next;
            dataAddrQ <= dataAddrNext;
            flipQ     <= flipNext;
        end
    end

    // Outputs decode registered state only; reset forces every term to zero.
    assign BusRequest        = (state == DATA);
    assign DataAck           = (state == DATA);
    assign FetchSurpress     = (state == FLUSH);
    assign Flags_5_PCRA_Flip = flipQ;
    assign PCRA0             = pcra0Q;
    assign PCRA1             = pcra1Q;
    assign MEMADDR           = (state == DATA) ? dataAddrQ : (flipQ ? pcra1Q : pcra0Q);

endmodule

// File: tb/tb_pcra_fetch_address.sv
// Directed bench for pcra_fetch_address with hand-computed expectations.
module tb_pcra_fetch_address;

    logic        ClockIn = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Pipe0Out_0_IncPCRA0 = 1'b0;
    logic        Pipe0Out_1_IncPCRA1 = 1'b0;
    logic        LoadPCRA0 = 1'b0;
    logic        LoadPCRA1 = 1'b0;
    logic [15:0] LoadData = '0;
    logic        FlipToggle = 1'b0;
    logic        DataReq = 1'b0;
    logic [15:0] DataAddr = '0;
    logic        DataAck;
    logic        BusRequest;
    logic        FetchSurpress;
    logic        Flags_5_PCRA_Flip;
    logic [15:0] MEMADDR;
    logic [15:0] PCRA0;
    logic [15:0] PCRA1;

    int assertCount = 0;
    int failCount   = 0;

    pcra_fetch_address #(.ADDR_W(16)) dut (
        .ClockIn(ClockIn),
        .Reset_n(Reset_n),
        .Pipe0Out_0_IncPCRA0(Pipe0Out_0_IncPCRA0),
        .Pipe0Out_1_IncPCRA1(Pipe0Out_1_IncPCRA1),
        .LoadPCRA0(LoadPCRA0),
        .LoadPCRA1(LoadPCRA1),
        .LoadData(LoadData),
        .FlipToggle(FlipToggle),
        .DataReq(DataReq),
        .DataAddr(DataAddr),
        .DataAck(DataAck),
        .BusRequest(BusRequest),
        .FetchSurpress(FetchSurpress),
        .Flags_5_PCRA_Flip(Flags_5_PCRA_Flip),
        .MEMADDR(MEMADDR),
        .PCRA0(PCRA0),
        .PCRA1(PCRA1)
    );

    always #5 ClockIn = ~ClockIn;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assertCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ClockIn);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkVal({tag, "_pcra0"}, PCRA0, 0);
        checkVal({tag, "_pcra1"}, PCRA1, 0);
        checkVal({tag, "_flag"}, Flags_5_PCRA_Flip, 0);
        checkVal({tag, "_memaddr"}, MEMADDR, 0);
        checkVal({tag, "_busreq"}, BusRequest, 0);
        checkVal({tag, "_ack"}, DataAck, 0);
        checkVal({tag, "_fsup"}, FetchSurpress, 0);
    endtask

    initial begin
        #3;
        checkAllZero("reset");
        tick();
        Reset_n = 1'b1;

        // Three increments of PCRA0 with flag 0
        Pipe0Out_0_IncPCRA0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("inc_busreq", BusRequest, 0);
            checkVal("inc_fsup", FetchSurpress, 0);
        end
        Pipe0Out_0_IncPCRA0 = 1'b0;
        checkVal("inc_pcra0", PCRA0, 16'h0003);
        checkVal("inc_memaddr", MEMADDR, 16'h0003);

        // Load PCRA1 (non-live before toggle) and flip in the same edge
        LoadPCRA1 = 1'b1; LoadData = 16'hFFFF; FlipToggle = 1'b1;
        tick();
        LoadPCRA1 = 1'b0; FlipToggle = 1'b0;
        checkVal("flip_flag", Flags_5_PCRA_Flip, 1);
        checkVal("flip_fsup", FetchSurpress, 0);
        checkVal("flip_memaddr", MEMADDR, 16'hFFFF);
        Pipe0Out_1_IncPCRA1 = 1'b1;
        tick();
        Pipe0Out_1_IncPCRA1 = 1'b0;
        checkVal("wrap_pcra1", PCRA1, 16'h0000);
        checkVal("wrap_memaddr", MEMADDR, 16'h0000);
        checkVal("wrap_pcra0", PCRA0, 16'h0003);

        // Flip back while loading PCRA0, which is non-live before the toggle
        FlipToggle = 1'b1; LoadPCRA0 = 1'b1; LoadData = 16'h0010;
        tick();
        FlipToggle = 1'b0; LoadPCRA0 = 1'b0;
        checkVal("back_flag", Flags_5_PCRA_Flip, 0);
        checkVal("back_fsup", FetchSurpress, 0);
        checkVal("back_memaddr", MEMADDR, 16'h0010);

        // Data access; live increment ignored during DATA, non-live applies
        DataReq = 1'b1; DataAddr = 16'h1234;
        tick();
        checkVal("data_busreq", BusRequest, 1);
        checkVal("data_ack", DataAck, 1);
        checkVal("data_memaddr", MEMADDR, 16'h1234);
        checkVal("data_fsup", FetchSurpress, 0);
        DataReq = 1'b0; Pipe0Out_0_IncPCRA0 = 1'b1; Pipe0Out_1_IncPCRA1 = 1'b1;
        tick();
        Pipe0Out_0_IncPCRA0 = 1'b0; Pipe0Out_1_IncPCRA1 = 1'b0;
        checkVal("post_busreq", BusRequest, 0);
        checkVal("post_ack", DataAck, 0);
        checkVal("post_memaddr", MEMADDR, 16'h0010);
        checkVal("post_pcra0", PCRA0, 16'h0010);
        checkVal("post_pcra1", PCRA1, 16'h0001);

        // Live load with increment and DataReq: FLUSH, FETCH, DATA, FETCH
        LoadPCRA0 = 1'b1; LoadData = 16'h0200; Pipe0Out_0_IncPCRA0 = 1'b1;
        DataReq = 1'b1; DataAddr = 16'h4000;
        tick();
        LoadPCRA0 = 1'b0; Pipe0Out_0_IncPCRA0 = 1'b0;
        checkVal("flush_fsup", FetchSurpress, 1);
        checkVal("flush_busreq", BusRequest, 0);
        checkVal("flush_pcra0", PCRA0, 16'h0200);
        checkVal("flush_memaddr", MEMADDR, 16'h0200);
        tick();
        checkVal("flush_end_fsup", FetchSurpress, 0);
        checkVal("flush_end_busreq", BusRequest, 0);
        tick();
        checkVal("late_busreq", BusRequest, 1);
        checkVal("late_ack", DataAck, 1);
        checkVal("late_memaddr", MEMADDR, 16'h4000);
        DataReq = 1'b0;
        tick();
        checkVal("late_done_busreq", BusRequest, 0);
        checkVal("late_done_memaddr", MEMADDR, 16'h0200);

        // Back-to-back live loads restart FLUSH
        LoadPCRA0 = 1'b1; LoadData = 16'h0300;
        tick();
        checkVal("restart1_fsup", FetchSurpress, 1);
        LoadData = 16'h0301;
        tick();
        LoadPCRA0 = 1'b0;
        checkVal("restart2_fsup", FetchSurpress, 1);
        checkVal("restart2_pcra0", PCRA0, 16'h0301);
        tick();
        checkVal("restart_end_fsup", FetchSurpress, 0);

        // Non-live load: no flush, address unchanged
        LoadPCRA1 = 1'b1; LoadData = 16'hABCD;
        tick();
        LoadPCRA1 = 1'b0;
        checkVal("nonlive_fsup", FetchSurpress, 0);
        checkVal("nonlive_memaddr", MEMADDR, 16'h0301);
        checkVal("nonlive_pcra1", PCRA1, 16'hABCD);

        // Reset asserted between edges in the middle of DATA
        DataReq = 1'b1; DataAddr = 16'h5555;
        tick();
        checkVal("pre_rst_busreq", BusRequest, 1);
        DataReq = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        checkAllZero("midrst");
        tick();
        checkVal("held_rst_ack", DataAck, 0);
        Reset_n = 1'b1;
        tick();
        checkAllZero("postrst");
        Pipe0Out_0_IncPCRA0 = 1'b1;
        tick();
        Pipe0Out_0_IncPCRA0 = 1'b0;
        checkVal("postrst_memaddr", MEMADDR, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
